// File: rtl/nmr_pkg.sv
// nmr_pkg: shared state encoding and default counter width for the NMR dump sequencer.
package nmr_pkg;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, DELAY, DUMP, GUARD} seq_state_t;
endpackage

// File: rtl/dn_counter.sv
// dn_counter: loadable down-counter that stops at zero and flags it.
module dn_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = ~|cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= val;
        else if (!zero) cnt <= cnt - W'(1);
    end
endmodule

// File: rtl/dump_sequencer.sv
// dump_sequencer: per-echo antenna dump pulse sequencer (dead time, dump width, receiver guard).
module dump_sequencer import nmr_pkg::*; #(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int GUARD_CYC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dumpoff,
    input  logic             rf_end,
    input  logic             abort,
    input  logic [CNT_W-1:0] dly_cfg,
    input  logic [CNT_W-1:0] wid_cfg,
    output logic             dump_out,
    output logic             busy,
    output logic             done,
    output logic             overrun
);
    localparam bit HAS_G = GUARD_CYC > 0;
    localparam logic [CNT_W-1:0] G_LD = CNT_W'(HAS_G ? GUARD_CYC - 1 : 0);
    seq_state_t state, nxt;
    logic active, accept, zero, ld, done_n;
    logic [CNT_W-1:0] ld_val, wid_q;
    assign active = state != IDLE;
    assign accept = rf_end && !dumpoff && !active;
    // counter holds remaining-cycles-minus-one, so a stage ends the cycle it reads zero
    assign ld = nxt != state && nxt != IDLE;
    dn_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .load (ld),
        .val  (ld_val),
        .zero (zero)
    );
    always_comb begin
        nxt    = state;
        ld_val = '0;
        done_n = 1'b0;
        case (state)
            IDLE:
                if (accept) begin
                    if (|dly_cfg) begin
                        nxt    = DELAY;
                        ld_val = dly_cfg - CNT_W'(1);
                    end else if (|wid_cfg) begin
                        nxt    = DUMP;
                        ld_val = wid_cfg - CNT_W'(1);
                    end else if (HAS_G) begin
                        nxt    = GUARD;
                        ld_val = G_LD;
                    end else done_n = 1'b1;
                end
            DELAY:
                if (zero) begin
                    if (|wid_q) begin
                        nxt    = DUMP;
                        ld_val = wid_q - CNT_W'(1);
                    end else if (HAS_G) begin
                        nxt    = GUARD;
                        ld_val = G_LD;
                    end else begin
                        nxt    = IDLE;
                        done_n = 1'b1;
                    end
                end
            DUMP:
                if (zero) begin
                    nxt    = HAS_G ? GUARD : IDLE;
                    ld_val = G_LD;
                    done_n = !HAS_G;
                end
            GUARD:
                if (zero) begin
                    nxt    = IDLE;
                    done_n = 1'b1;
                end
        endcase
        // abort wins over any transition, including the one into the done cycle
        if (abort && active) begin
            nxt    = IDLE;
            done_n = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wid_q    <= '0;
            dump_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= nxt;
            if (accept) wid_q <= wid_cfg;
            dump_out <= dumpoff || nxt == DUMP;
            busy     <= nxt != IDLE;
            done     <= done_n;
            overrun  <= overrun || (rf_end && active);
        end
    end
endmodule

// File: doc/dump_sequencer.md
Name: dump_sequencer

Overview:
- Per-echo antenna Q-damping ("dump") pulse sequencer for the NMR transmit/receive chain.
- Consumes the power-up `dumpoff` level and the pulse generator's end-of-RF strobe.
- For each accepted strobe, waits a programmable dead time, then drives the dump switch for a programmable width, then holds a fixed receiver guard interval.
- Reports completion to the acquisition controller, which opens the ADC window.

Parameters:
- CNT_W, 16, width of the delay and width counters and config inputs.
- GUARD_CYC, 8, fixed guard cycles after the dump pulse before `done`; 0 is legal.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- dumpoff, input, 1, power-up dump level from the upstream dump-release block. While high, the antenna is held shorted.
- rf_end, input, 1, single-cycle strobe at the end of each RF pulse.
- abort, input, 1, synchronous abort of the sequence in progress.
- dly_cfg, input, CNT_W, dead time in clk cycles, sampled at acceptance.
- wid_cfg, input, CNT_W, dump pulse width in clk cycles, sampled at acceptance.
- dump_out, output, 1, dump switch drive, registered.
- busy, output, 1, high while a sequence is active (any state other than IDLE).
- done, output, 1, single-cycle completion strobe.
- overrun, output, 1, sticky flag: an `rf_end` was dropped.

Behaviour:
- Reset (sync, active-high, clk edge): state=IDLE, counters=0, dump_out=0, busy=0, done=0, overrun=0. Reset mid-sequence discards everything; no `done` is issued.
- All outputs are registered. `dump_out` = `dumpoff` OR `seq_dump`, where `seq_dump` is the registered DUMP-state output.
- FSM states: IDLE, DELAY, DUMP, GUARD.
- IDLE:
  - `rf_end`=1 and `dumpoff`=0: accept. Latch `dly_cfg`/`wid_cfg` into shadow registers. Next state is DELAY if dly>0; else DUMP if wid>0; else GUARD if GUARD_CYC>0; else done pulse and remain IDLE.
  - `rf_end` while `dumpoff`=1: ignored. Not an overrun; the antenna is already shorted.
- DELAY: count dly cycles, then go to DUMP. If wid=0, skip to GUARD/done using the same rule as IDLE.
- DUMP: `seq_dump`=1 for exactly wid cycles, then GUARD (or done if GUARD_CYC=0).
- GUARD: GUARD_CYC cycles, then `done`=1 for one cycle and return to IDLE.
- Timing contract (rf_end high in cycle 0, all lengths nonzero):
  - busy high in cycles 1 .. dly+wid+GUARD_CYC.
  - seq_dump high in cycles dly+1 .. dly+wid.
  - done high in cycle dly+wid+GUARD_CYC+1, with busy=0 in that cycle.
  - A new `rf_end` is acceptable in the done cycle.
- `rf_end` while busy=1: dropped; overrun←1 (sticky until reset). The sequence in progress is unaffected.
- abort while busy: next edge forces IDLE and seq_dump=0. No done pulse. abort has priority over any transition in the same cycle. abort in IDLE has no effect.
- Config changes while busy have no effect; shadow registers are used.
- Counters never wrap: max dly/wid = 2^CNT_W−1 cycles, exact.
- `dumpoff` rising mid-sequence: dump_out goes high immediately (registered). Sequence timing continues unchanged.

Decomposition:
- Shared package `nmr_pkg`: state encoding typedef (IDLE/DELAY/DUMP/GUARD) and the default CNT_W constant.
- One sub-module is natural: `dn_counter` (loadable down-counter with zero flag, CNT_W wide). It is reused for DELAY, DUMP and GUARD; the rest is a single FSM.

Test Plan:
- Reset release with dumpoff=1, rf_end pulsed → dump_out=1, busy=0, overrun=0, no done.
- dumpoff=0, dly=5, wid=3, GUARD_CYC=8, rf_end at cycle 0 → dump_out high cycles 6–8, busy cycles 1–16, done at cycle 17 only.
- dly=0, wid=0 → busy cycles 1–8, no dump_out, done at cycle 9. Repeat with GUARD_CYC=0 → done at cycle 1, busy never high.
- Second rf_end at cycle 4 of a dly=5/wid=3 sequence → original timing unchanged, overrun=1 and stays 1 until reset.
- abort at cycle 7 (during DUMP) → cycle 8 dump_out=0, busy=0, no done. Then rf_end at cycle 10 runs a clean full sequence.
- dly=0xFFFF, wid=1 → dump_out high exactly cycle 65536, no wrap. dly_cfg changed at cycle 100 → no effect on timing.
